// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU execute unit with iterative SLL and valid/ready handshakes
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_control,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, alu_r;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, ill_q, ill_d;
  logic accept, is_sll, is_ill, slt;
  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  assign is_sll    = (alu_control == 3'b011);
  assign is_ill    = (alu_control[2:1] == 2'b10);
  assign slt       = $signed(a) < $signed(b);
  // SLL loads b here; the SHIFT state does the actual shifting
  always_comb
    alu_r = alu_control == 3'b010 ? a + b :
            alu_control == 3'b110 ? a - b :
            alu_control == 3'b000 ? a & b :
            alu_control == 3'b001 ? a | b :
            alu_control == 3'b111 ? {{(WIDTH-1){1'b0}}, slt} :
            alu_control == 3'b011 ? b : '0;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d = alu_r;
        cnt_d = shamt;
        ill_d = is_ill;
        if (is_sll && shamt != '0) state_d = SHIFT;
        else begin
          state_d = DONE;
          zero_d  = (alu_r == '0);
        end
      end
      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
          zero_d  = ((acc_q << 1) == '0);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and random checks of alu_seq_exec against a behavioural model
module tb_alu_seq_exec;
  logic        clk, reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [2:0]  alu_control;
  logic [31:0] a, b, result;
  logic [4:0]  shamt;
  int n_cmp = 0, n_bad = 0;

  alu_seq_exec dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, y, input logic [4:0] s);
    case (op)
      3'b010: return x + y;
      3'b110: return x - y;
      3'b000: return x & y;
      3'b001: return x | y;
      3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'b011: return y << s;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run(input logic [2:0] op, input logic [31:0] av, bv, input logic [4:0] sh,
                     input int hold, input bit noise);
    logic [31:0] exp_r;
    int exp_lat, lat;
    exp_r   = model(op, av, bv, sh);
    exp_lat = (op == 3'b011 && sh != 0) ? int'(sh) + 1 : 1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1; alu_control = op; a = av; b = bv; shamt = sh;
    @(posedge clk); #1;
    alu_control = 3'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    in_valid = noise; out_ready = noise;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) chk("busy_ready", in_ready, 0);
    end while (!out_valid && lat < 40);
    out_ready = 0;
    chk("latency", lat, exp_lat);
    chk("result", result, exp_r);
    chk("zero", zero, exp_r == 0);
    chk("illegal", illegal, op == 3'b100 || op == 3'b101);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, exp_r);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 0; alu_control = 0; a = 0; b = 0; shamt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_illegal", illegal, 0);
    reset = 0;
    run(3'b010, 5, 7, 0, 0, 0);
    run(3'b110, 3, 3, 0, 0, 0);
    run(3'b111, 32'hFFFF_FFFF, 1, 0, 0, 0);
    run(3'b011, 1, 1, 31, 0, 0);
    run(3'b001, 32'hF0, 32'h0F, 0, 3, 0);
    run(3'b011, 32'hDEAD_BEEF, 0, 0, 1, 0);
    run(3'b011, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run(3'b011, 0, 32'hFFFF_FFFF, 31, 0, 1);
    run(3'b100, 9, 9, 0, 1, 0);
    run(3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0);
    run(3'b101, 1, 2, 3, 0, 1);
    run(3'b111, 1, 32'hFFFF_FFFF, 0, 0, 0);
    // abort a long shift with reset partway through
    @(negedge clk);
    in_valid = 1; alu_control = 3'b011; b = 32'h1234_5678; shamt = 20;
    @(posedge clk); #1 in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_ready", in_ready, 0);
    @(negedge clk) reset = 0;
    #1 chk("abort_ready_after", in_ready, 1);
    run(3'b010, 32'hFFFF_FFFF, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      run(3'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
